// File: rtl/sram_sync_ctrl.sv
// Single-port synchronous SRAM with a valid/ready request port, a read pipeline and a post-reset clear.
// Latency: read data and rd_valid appear READ_LATENCY cycles after acceptance; writes take effect at acceptance.
// Backpressure: req_ready stays low until the clear finishes, then stays high. Reads cannot be stalled.
module sram_sync_ctrl #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    DEPTH        = 1024,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chip_select,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  read_write_select,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  init_done
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  // Widened by one bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   pipe_dat [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld;
  logic                    accept;
  logic                    in_range;
  logic                    wr_en;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign accept   = chip_select & req_valid & req_ready;
  assign in_range = {1'b0, address} < DEPTH_EXT;
  assign wr_en    = accept & read_write_select & in_range;
  assign rd_en    = accept & ~read_write_select;
  // Out-of-range reads still produce a response, carrying zero.
  assign rd_word  = in_range ? mem[address] : '0;

  // Clear sequencer: walk every word once after reset, then serve requests until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (clr_cnt == LAST_ADDR) begin
            state     <= ST_READY;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_READY: begin
          init_done <= 1'b1;
          req_ready <= 1'b1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Storage: clear writes own the port during INIT, accepted in-range writes afterwards; no reset on the array.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[clr_cnt] <= INIT_VALUE;
      end else if (wr_en) begin
        mem[address] <= data_in;
      end
    end
  end

  // Read valid shift chain; cleared by reset so in-flight reads are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_en;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
      end
    end
  end

  // Read data shift chain; stage 0 samples the array at the accepting edge.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      pipe_dat[0] <= rd_word;
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_dat[k] <= pipe_dat[k-1];
    end
  end

  // Output register: data_out only moves when a read completes, so it holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      data_out <= '0;
    end else begin
      rd_valid <= pipe_vld[READ_LATENCY-1];
      if (pipe_vld[READ_LATENCY-1]) begin
        data_out <= pipe_dat[READ_LATENCY-1];
      end
    end
  end

endmodule

// File: tb/tb_sram_sync_ctrl.sv
// Directed bench for sram_sync_ctrl with a queue-based read scoreboard.
// Instance a uses the default parameters; instance b uses READ_LATENCY=3, DEPTH=1000.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sram_sync_ctrl;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  logic       rst_a, cs_a, vld_a, rws_a, rdy_a, rdv_a, idone_a;
  logic [9:0] addr_a;
  logic [7:0] din_a, dout_a;
  logic       rst_b, cs_b, vld_b, rws_b, rdy_b, rdv_b, idone_b;
  logic [9:0] addr_b;
  logic [7:0] din_b, dout_b;

  sram_sync_ctrl dut_a (
    .clk(clk), .rst(rst_a), .chip_select(cs_a), .req_valid(vld_a), .req_ready(rdy_a),
    .read_write_select(rws_a), .address(addr_a), .data_in(din_a), .data_out(dout_a),
    .rd_valid(rdv_a), .init_done(idone_a)
  );

  sram_sync_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(10), .DEPTH(1000), .READ_LATENCY(3), .INIT_VALUE(8'h00)
  ) dut_b (
    .clk(clk), .rst(rst_b), .chip_select(cs_b), .req_valid(vld_b), .req_ready(rdy_b),
    .read_write_select(rws_b), .address(addr_b), .data_in(din_b), .data_out(dout_b),
    .rd_valid(rdv_b), .init_done(idone_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request on instance a; reads push their expected data and completion cycle.
  task automatic op_a(input logic w, input int a, input int d);
    @(negedge clk);
    cs_a = 1'b1; vld_a = 1'b1; rws_a = w; addr_a = 10'(a); din_a = 8'(d);
    if (!w) q_a.push_back('{d: 8'(d), due: cyc + 2});
  endtask

  task automatic op_b(input logic w, input int a, input int d);
    @(negedge clk);
    cs_b = 1'b1; vld_b = 1'b1; rws_b = w; addr_b = 10'(a); din_b = 8'(d);
    if (!w) q_b.push_back('{d: 8'(d), due: cyc + 4});
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin @(negedge clk); vld_a = 1'b0; cs_a = 1'b1; end
  endtask

  task automatic idle_b(input int n);
    repeat (n) begin @(negedge clk); vld_b = 1'b0; cs_b = 1'b1; end
  endtask

  // Monitor for instance a: every rd_valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rdv_a === 1'b1) begin
      if (q_a.size() == 0) check("a_spurious_rd_valid", 1, 0);
      else begin
        e = q_a.pop_front();
        check("a_rd_data", dout_a, e.d);
        check("a_rd_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rdv_b === 1'b1) begin
      if (q_b.size() == 0) check("b_spurious_rd_valid", 1, 0);
      else begin
        e = q_b.pop_front();
        check("b_rd_data", dout_b, e.d);
        check("b_rd_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    int n;
    rst_a = 1'b1; cs_a = 1'b0; vld_a = 1'b0; rws_a = 1'b0; addr_a = '0; din_a = '0;
    rst_b = 1'b1; cs_b = 1'b0; vld_b = 1'b0; rws_b = 1'b0; addr_b = '0; din_b = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check("a_rst_req_ready", rdy_a, 0);
    check("a_rst_rd_valid", rdv_a, 0);
    check("a_rst_data_out", dout_a, 0);
    check("a_rst_init_done", idone_a, 0);
    check("b_rst_req_ready", rdy_b, 0);
    check("b_rst_init_done", idone_b, 0);

    // Clear sequence length on the default configuration
    rst_a = 1'b0;
    n = 0;
    while (idone_a !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("a_init_cycles", n, 1024);
    check("a_req_ready_after_init", rdy_a, 1);

    // chip_select low: neither writes nor reads may take effect
    repeat (5) begin
      @(negedge clk); cs_a = 1'b0; vld_a = 1'b1; rws_a = 1'b1; addr_a = 10'd3; din_a = 8'hFF;
    end
    repeat (2) begin
      @(negedge clk); cs_a = 1'b0; vld_a = 1'b1; rws_a = 1'b0; addr_a = 10'd3;
    end
    op_a(0, 517, 8'h00);
    op_a(0, 3, 8'h00);
    idle_a(4);

    // Write sweep then back-to-back read sweep
    for (int i = 0; i < 1024; i++) op_a(1, i, (2 * i) % 256);
    for (int i = 0; i < 1024; i++) op_a(0, i, (2 * i) % 256);
    idle_a(4);
    check("a_dout_after_sweep", dout_a, 8'hFE);

    // Read-after-write, then a later write must not disturb data_out
    op_a(1, 7, 8'hA5);
    op_a(0, 7, 8'hA5);
    idle_a(1);
    op_a(1, 7, 8'h3C);
    idle_a(3);
    check("a_dout_hold_over_write", dout_a, 8'hA5);
    op_a(0, 7, 8'h3C);
    idle_a(3);

    // Reset partway through the clear restarts it from scratch
    @(negedge clk); rst_a = 1'b1; vld_a = 1'b0;
    @(negedge clk);
    check("a_rst_clears_dout", dout_a, 0);
    rst_a = 1'b0;
    repeat (500) @(negedge clk);
    check("a_init_done_mid_clear", idone_a, 0);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    n = 0;
    while (idone_a !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("a_reinit_cycles", n, 1024);
    op_a(0, 7, 8'h00);
    op_a(0, 200, 8'h00);
    idle_a(4);
    check("a_queue_drained", q_a.size(), 0);

    // Instance b: latency 3, non-power-of-two depth
    @(negedge clk); rst_b = 1'b0;
    n = 0;
    while (idone_b !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("b_init_cycles", n, 1000);
    op_b(1, 10, 8'h11);
    op_b(1, 11, 8'h22);
    op_b(1, 999, 8'h99);
    op_b(1, 1005, 8'hEE);
    op_b(0, 10, 8'h11);
    op_b(0, 11, 8'h22);
    op_b(0, 999, 8'h99);
    op_b(0, 1000, 8'h00);
    op_b(0, 1005, 8'h00);
    op_b(0, 5, 8'h00);
    op_b(0, 999, 8'h99);
    idle_b(6);
    check("b_dout_last_read", dout_b, 8'h99);

    // Two reads in flight when reset hits: both must be dropped
    @(negedge clk); cs_b = 1'b1; vld_b = 1'b1; rws_b = 1'b0; addr_b = 10'd10;
    @(negedge clk); addr_b = 10'd11;
    @(negedge clk); vld_b = 1'b0; rst_b = 1'b1;
    @(negedge clk);
    check("b_rst_rd_valid", rdv_b, 0);
    check("b_rst_data_out", dout_b, 0);
    check("b_rst_init_done", idone_b, 0);
    rst_b = 1'b0;
    n = 0;
    while (idone_b !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("b_reinit_cycles", n, 1000);
    check("b_dout_after_reinit", dout_b, 0);
    op_b(0, 10, 8'h00);
    op_b(0, 999, 8'h00);
    idle_b(6);
    check("b_queue_drained", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_sync_ctrl.md
Name: sram_sync_ctrl

Overview:
- Parametrised, clocked successor to the team's asynchronous single-port SRAM.
- Replaces the bidirectional data bus with separate data_in and data_out ports.
- Adds a valid/ready request handshake, a configurable read pipeline and a post-reset memory-clear sequencer.
- Sits between a bus master and on-chip storage, and serves as the standard storage macro for later designs.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 10, address width in bits.
- DEPTH, 1024, number of words (≤ 2**ADDR_WIDTH); need not be a power of two.
- READ_LATENCY, 1, cycles from request acceptance to read data valid; legal range 1..4.
- INIT_VALUE, 0, value written to every word during the clear sequence.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- chip_select, input, 1, enables request acceptance.
- req_valid, input, 1, request present this cycle.
- req_ready, output, 1, block can accept a request.
- read_write_select, input, 1, 1 = write, 0 = read.
- address, input, ADDR_WIDTH, word address.
- data_in, input, DATA_WIDTH, write data.
- data_out, output, DATA_WIDTH, read data; holds its last value.
- rd_valid, output, 1, one-cycle pulse when data_out carries new read data.
- init_done, output, 1, high once the clear sequence has completed.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on rising clk.
- Reset values: req_ready=0, rd_valid=0, data_out=0, init_done=0, FSM=INIT, clear counter=0, read pipeline valid bits all 0.
- FSM states:
  - INIT: each cycle writes mem[cnt]=INIT_VALUE and increments cnt. After the edge that writes DEPTH-1, move to READY and set init_done=1. The clear takes exactly DEPTH cycles.
  - READY: req_ready=1. The FSM never leaves READY except through rst.
- req_ready equals init_done and is independent of chip_select and req_valid.
- Accept condition at edge N: chip_select & req_valid & req_ready. No accept means no memory access and no pipeline entry.
- Write accepted at edge N: mem[address]=data_in takes effect at edge N. No rd_valid is generated.
- Read accepted at edge N: mem[address] is sampled at edge N and enters a READ_LATENCY-stage shift pipeline.
  - data_out updates and rd_valid goes high at edge N+READ_LATENCY.
  - rd_valid drops at the next edge unless another read completes then.
- Fully pipelined: one request per cycle. Back-to-back reads give back-to-back rd_valid pulses, in order.
- Read-after-write: a read accepted at edge N+1 to the address written at edge N returns the new data.
- Same-cycle read/write conflicts are impossible on a single port.
- Address ≥ DEPTH:
  - write is accepted and ignored (memory unchanged);
  - read is accepted and returns 0 with a normal rd_valid pulse.
- data_out holds its value between reads. Writes never change data_out.
- Reset during INIT restarts the clear from address 0; init_done stays 0.
- Reset with reads in flight:
  - all pipeline valid bits clear, so no rd_valid is issued for those reads;
  - data_out returns to 0;
  - memory is fully re-cleared by INIT.
- Memory array has no direct reset; only INIT initialises it.

Test Plan:
- Defaults, assert rst 2 cycles then release → req_ready=0 for exactly 1024 cycles; init_done and req_ready rise at the edge ending cycle 1024. Read of address 517 then returns 0x00 with rd_valid 1 cycle after acceptance.
- Write sweep: write data = (2*i) mod 256 to addresses i=0..1023 back-to-back, then read 0..1023 back-to-back → 1024 consecutive rd_valid pulses, in order, with data_out = (2*i) mod 256 (e.g. addr 200 → 0x90). No gaps.
- Read-after-write: write 0xA5 to addr 7 at edge N, read addr 7 at edge N+1 → data_out=0xA5 with rd_valid at edge N+2. A write of 0x3C to addr 7 at N+3 leaves data_out at 0xA5.
- READ_LATENCY=3, DEPTH=1000: reads of addr 10, 11, 999 at edges N..N+2 → rd_valid at N+3..N+5 with the stored data. A read of addr 1000 returns 0; a write to addr 1005 does not disturb any stored word.
- chip_select=0 with req_valid=1, rws=1, addr 3, data 0xFF for 5 cycles → addr 3 still reads 0x00 and no rd_valid pulse appears.
- Assert rst at cycle 500 of INIT, and separately with 2 reads in flight (READ_LATENCY=3) → INIT restarts (init_done low another 1024 cycles after release), no rd_valid pulse, data_out=0.
